// File: rtl/filter_pair_generator_if.sv
// Particle-pair handshake bundle between the pair generator, its position memories and the filter bank.
// Pure wiring, no latency of its own.
// Back pressure travels from the filter bank to the generator; input_valid travels the other way.
interface filter_pair_generator_if #(
    parameter int DATA_WIDTH          = 32,
    parameter int NUM_FILTER          = 4,
    parameter int PARTICLE_ADDR_WIDTH = 7
);
    logic                             start;
    logic                             home_cell;
    logic [PARTICLE_ADDR_WIDTH-1:0]   num_ref;
    logic [PARTICLE_ADDR_WIDTH-1:0]   num_nbr;
    logic [PARTICLE_ADDR_WIDTH-1:0]   ref_rd_addr;
    logic [3*DATA_WIDTH-1:0]          ref_rd_data;
    logic [PARTICLE_ADDR_WIDTH-1:0]   nbr_rd_addr;
    logic [3*DATA_WIDTH-1:0]          nbr_rd_data;
    logic [NUM_FILTER-1:0]            back_pressure;
    logic [NUM_FILTER-1:0]            input_valid;
    logic [NUM_FILTER*DATA_WIDTH-1:0] refx;
    logic [NUM_FILTER*DATA_WIDTH-1:0] refy;
    logic [NUM_FILTER*DATA_WIDTH-1:0] refz;
    logic [NUM_FILTER*DATA_WIDTH-1:0] neighborx;
    logic [NUM_FILTER*DATA_WIDTH-1:0] neighbory;
    logic [NUM_FILTER*DATA_WIDTH-1:0] neighborz;
    logic                             busy;
    logic                             done;

    // Generator side
    modport master (
        input  start, home_cell, num_ref, num_nbr, ref_rd_data, nbr_rd_data, back_pressure,
        output ref_rd_addr, nbr_rd_addr, input_valid,
               refx, refy, refz, neighborx, neighbory, neighborz, busy, done
    );

    // Environment side: control, memories and filter bank
    modport slave (
        output start, home_cell, num_ref, num_nbr, ref_rd_data, nbr_rd_data, back_pressure,
        input  ref_rd_addr, nbr_rd_addr, input_valid,
               refx, refy, refz, neighborx, neighbory, neighborz, busy, done
    );
endinterface

// File: rtl/filter_pair_generator.sv
// Walks every (reference, neighbor) particle pair of a cell pair and deals them round-robin to filter lanes.
// Latency: 2 cycles from issue (addresses presented) to input_valid/coordinates on the chosen lane.
// Backpressure: a pair is issued only to a lane with back_pressure low; all lanes pressured stalls the walk.
module filter_pair_generator #(
    parameter int DATA_WIDTH          = 32,
    parameter int NUM_FILTER          = 4,
    parameter int PARTICLE_ADDR_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    filter_pair_generator_if.master bus
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = PARTICLE_ADDR_WIDTH;
    localparam int CW = PARTICLE_ADDR_WIDTH + 1;
    localparam int LW = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_home;
    logic [AW-1:0]          r_num_ref;
    logic [AW-1:0]          r_num_nbr;
    logic [AW-1:0]          r_r;
    logic [AW-1:0]          r_n;
    logic [LW-1:0]          r_ptr;
    logic                   r_drain;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_p1_vld;
    logic [LW-1:0]          r_p1_lane;
    logic [NUM_FILTER-1:0]  r_vld;
    logic [NUM_FILTER*DW-1:0] r_refx, r_refy, r_refz;
    logic [NUM_FILTER*DW-1:0] r_nbrx, r_nbry, r_nbrz;

    logic                   w_empty;
    logic [CW-1:0]          w_r_inc;
    logic [CW-1:0]          w_n_inc;
    logic [CW-1:0]          w_n_wrap;
    logic [CW-1:0]          w_bound;
    logic                   w_adv_n;
    logic                   w_last;
    logic                   w_found;
    logic [LW-1:0]          w_lane;
    logic [LW-1:0]          w_ptr_nxt;

    // Index arithmetic is one bit wider than the counts so r+1 at the maximum count cannot wrap.
    // A home cell bounds both indices by the neighbor count.
    assign w_empty   = (r_num_ref == '0) || (r_num_nbr == '0) || (r_home && (r_num_nbr < AW'(2)));
    assign w_r_inc   = {1'b0, r_r} + CW'(1);
    assign w_n_inc   = {1'b0, r_n} + CW'(1);
    assign w_n_wrap  = r_home ? (w_r_inc + CW'(1)) : '0;
    assign w_bound   = r_home ? {1'b0, r_num_nbr} : {1'b0, r_num_ref};
    assign w_adv_n   = (w_n_inc < {1'b0, r_num_nbr});
    assign w_last    = !w_adv_n &&
                       ((w_r_inc == w_bound) || (r_home && (w_n_wrap >= {1'b0, r_num_nbr})));
    assign w_ptr_nxt = LW'((int'(w_lane) + 1) % NUM_FILTER);

    // Round-robin pick: first free lane at or after the pointer (reverse scan so the nearest wins).
    always_comb begin
        w_found = 1'b0;
        w_lane  = '0;
        for (int j = NUM_FILTER - 1; j >= 0; j--) begin
            if (!bus.back_pressure[(int'(r_ptr) + j) % NUM_FILTER]) begin
                w_found = 1'b1;
                w_lane  = LW'((int'(r_ptr) + j) % NUM_FILTER);
            end
        end
    end

    // Control FSM: job latch, pair walk, lane pointer, issue stage and busy/done flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_home    <= 1'b0;
            r_num_ref <= '0;
            r_num_nbr <= '0;
            r_r       <= '0;
            r_n       <= '0;
            r_ptr     <= '0;
            r_drain   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_p1_vld  <= 1'b0;
            r_p1_lane <= '0;
        end else begin
            r_p1_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_home    <= bus.home_cell;
                        r_num_ref <= bus.num_ref;
                        r_num_nbr <= bus.num_nbr;
                        r_r       <= '0;
                        r_n       <= bus.home_cell ? AW'(1) : '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_empty) begin
                        r_drain <= 1'b0;
                        r_state <= S_DRAIN;
                    end else if (w_found) begin
                        r_p1_vld  <= 1'b1;
                        r_p1_lane <= w_lane;
                        r_ptr     <= w_ptr_nxt;
                        if (w_adv_n) begin
                            r_n <= r_n + AW'(1);
                        end else begin
                            r_r <= w_r_inc[AW-1:0];
                            r_n <= w_n_wrap[AW-1:0];
                        end
                        if (w_last) begin
                            r_drain <= 1'b0;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Two cycles let the last issued pair reach its lane before done.
                    if (r_drain) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output stage: load the chosen lane from the memory data that arrives the cycle after issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld  <= '0;
            r_refx <= '0;
            r_refy <= '0;
            r_refz <= '0;
            r_nbrx <= '0;
            r_nbry <= '0;
            r_nbrz <= '0;
        end else begin
            r_vld <= '0;
            if (r_p1_vld) begin
                r_vld[r_p1_lane]              <= 1'b1;
                r_refx[r_p1_lane*DW +: DW]    <= bus.ref_rd_data[DW-1:0];
                r_refy[r_p1_lane*DW +: DW]    <= bus.ref_rd_data[2*DW-1:DW];
                r_refz[r_p1_lane*DW +: DW]    <= bus.ref_rd_data[3*DW-1:2*DW];
                r_nbrx[r_p1_lane*DW +: DW]    <= bus.nbr_rd_data[DW-1:0];
                r_nbry[r_p1_lane*DW +: DW]    <= bus.nbr_rd_data[2*DW-1:DW];
                r_nbrz[r_p1_lane*DW +: DW]    <= bus.nbr_rd_data[3*DW-1:2*DW];
            end
        end
    end

    assign bus.ref_rd_addr = r_r;
    assign bus.nbr_rd_addr = r_n;
    assign bus.input_valid = r_vld;
    assign bus.refx        = r_refx;
    assign bus.refy        = r_refy;
    assign bus.refz        = r_refz;
    assign bus.neighborx   = r_nbrx;
    assign bus.neighbory   = r_nbry;
    assign bus.neighborz   = r_nbrz;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_filter_pair_generator.sv
// Self-checking bench for filter_pair_generator: queue-based pair model, per-cycle compare, directed and random jobs.
// Latency checked: issue to lane output 2 cycles, done 3 cycles after the last issue.
// Backpressure driven per cycle: fixed masks, a full stall window and random masks.
module tb_filter_pair_generator;
    localparam int DW = 32;
    localparam int NF = 4;
    localparam int AW = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    filter_pair_generator_if #(.DATA_WIDTH(DW), .NUM_FILTER(NF), .PARTICLE_ADDR_WIDTH(AW)) bus ();

    filter_pair_generator #(.DATA_WIDTH(DW), .NUM_FILTER(NF), .PARTICLE_ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    logic [3*DW-1:0] ref_mem [0:127];
    logic [3*DW-1:0] nbr_mem [0:127];

    // Position memories: one-cycle read latency
    always @(posedge clk) begin
        bus.ref_rd_data <= ref_mem[bus.ref_rd_addr];
        bus.nbr_rd_data <= nbr_mem[bus.nbr_rd_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // All pairs a job must produce, in issue order
    function automatic void make_pairs(input bit home, input int nr, input int nn,
                                       output int pr[$], output int pn[$]);
        int rmax;
        pr.delete();
        pn.delete();
        if (nr != 0 && nn != 0) begin
            rmax = home ? nn : nr;
            for (int r = 0; r < rmax; r++)
                for (int n = (home ? r + 1 : 0); n < nn; n++) begin
                    pr.push_back(r);
                    pn.push_back(n);
                end
        end
    endfunction

    // ---------------- behavioural model ----------------
    int              m_phase;   // 0 idle, 1 walking pairs, 2 flushing, 3 done
    int              m_dcnt;
    int              m_ptr;
    int              q_r[$];
    int              q_n[$];
    bit              s1_vld;
    int              s1_lane, s1_r, s1_n;
    logic [NF-1:0]   m_vld;
    logic [DW-1:0]   m_coord [NF][6];

    always @(posedge clk) begin
        int lane;
        cyc++;
        if (!rst_n) begin
            m_phase = 0;
            m_dcnt  = 0;
            m_ptr   = 0;
            q_r.delete();
            q_n.delete();
            s1_vld  = 0;
            m_vld   = '0;
            for (int l = 0; l < NF; l++)
                for (int f = 0; f < 6; f++) m_coord[l][f] = '0;
        end else begin
            m_vld = '0;
            if (s1_vld) begin
                m_vld[s1_lane] = 1'b1;
                m_coord[s1_lane][0] = ref_mem[s1_r][DW-1:0];
                m_coord[s1_lane][1] = ref_mem[s1_r][2*DW-1:DW];
                m_coord[s1_lane][2] = ref_mem[s1_r][3*DW-1:2*DW];
                m_coord[s1_lane][3] = nbr_mem[s1_n][DW-1:0];
                m_coord[s1_lane][4] = nbr_mem[s1_n][2*DW-1:DW];
                m_coord[s1_lane][5] = nbr_mem[s1_n][3*DW-1:2*DW];
            end
            s1_vld = 0;
            case (m_phase)
                0: if (bus.start) begin
                    make_pairs(bus.home_cell, int'(bus.num_ref), int'(bus.num_nbr), q_r, q_n);
                    m_phase = 1;
                end
                1: begin
                    if (q_r.size() == 0) begin
                        m_phase = 2;
                        m_dcnt  = 0;
                    end else begin
                        lane = -1;
                        for (int j = 0; j < NF; j++)
                            if (lane < 0 && !bus.back_pressure[(m_ptr + j) % NF]) lane = (m_ptr + j) % NF;
                        if (lane >= 0) begin
                            s1_vld  = 1;
                            s1_lane = lane;
                            s1_r    = q_r.pop_front();
                            s1_n    = q_n.pop_front();
                            m_ptr   = (lane + 1) % NF;
                            if (q_r.size() == 0) begin
                                m_phase = 2;
                                m_dcnt  = 0;
                            end
                        end
                    end
                end
                2: if (m_dcnt == 1) m_phase = 3; else m_dcnt = 1;
                default: m_phase = 0;
            endcase
        end
    end

    function automatic logic [DW-1:0] field(input int l, input int f);
        case (f)
            0:       return bus.refx[l*DW +: DW];
            1:       return bus.refy[l*DW +: DW];
            2:       return bus.refz[l*DW +: DW];
            3:       return bus.neighborx[l*DW +: DW];
            4:       return bus.neighbory[l*DW +: DW];
            default: return bus.neighborz[l*DW +: DW];
        endcase
    endfunction

    // ---------------- compare process and event log ----------------
    int  lane_log[$];
    int  v_cnt;
    int  first_v;
    int  done_cyc;
    bit  done_seen;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", 128'(bus.busy), 128'(0));
            chk("rst_done", 128'(bus.done), 128'(0));
            chk("rst_valid", 128'(bus.input_valid), 128'(0));
            chk("rst_raddr", 128'(bus.ref_rd_addr), 128'(0));
            chk("rst_naddr", 128'(bus.nbr_rd_addr), 128'(0));
            for (int l = 0; l < NF; l++)
                for (int f = 0; f < 6; f++) chk("rst_coord", 128'(field(l, f)), 128'(0));
        end else begin
            chk("busy", 128'(bus.busy), 128'(m_phase != 0));
            chk("done", 128'(bus.done), 128'(m_phase == 3));
            chk("valid", 128'(bus.input_valid), 128'(m_vld));
            for (int l = 0; l < NF; l++)
                for (int f = 0; f < 6; f++) chk("coord", 128'(field(l, f)), 128'(m_coord[l][f]));
            if (m_phase == 1 && q_r.size() != 0) begin
                chk("ref_addr", 128'(bus.ref_rd_addr), 128'(q_r[0]));
                chk("nbr_addr", 128'(bus.nbr_rd_addr), 128'(q_n[0]));
            end
            if (bus.input_valid != '0) begin
                if (first_v < 0) first_v = cyc;
                v_cnt++;
                for (int l = 0; l < NF; l++) if (bus.input_valid[l]) lane_log.push_back(l);
            end
            if (bus.done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic fill_mem();
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = {$urandom, $urandom, $urandom};
            nbr_mem[i] = {$urandom, $urandom, $urandom};
        end
    endtask

    // mode: 0 free, 1 lane 1 held, 2 full stall rel 3..7, 3 random, 4 stray start at rel 2
    task automatic do_job(input bit home, input int nr, input int nn, input int mode,
                          output int off, output int foff);
        int t0, rel;
        bit got;
        lane_log.delete();
        v_cnt = 0; first_v = -1; done_seen = 0; done_cyc = 0;
        t0  = cyc;
        got = 0;
        bus.home_cell = home;
        bus.num_ref   = AW'(nr);
        bus.num_nbr   = AW'(nn);
        for (int i = 0; i < 20000 && !got; i++) begin
            rel = cyc - t0;
            bus.start = (rel == 0) || (mode == 3 && rel > 0 && $urandom_range(0, 7) == 0) ||
                        (mode == 4 && rel == 2);
            if (rel > 0 && bus.start) begin
                bus.home_cell = 1'($urandom);
                bus.num_ref   = AW'($urandom_range(1, 20));
                bus.num_nbr   = AW'($urandom_range(2, 20));
            end
            case (mode)
                1:       bus.back_pressure = 4'b0010;
                2:       bus.back_pressure = (rel >= 3 && rel <= 7) ? 4'b1111 : 4'b0000;
                3:       bus.back_pressure = NF'($urandom_range(0, 15) & $urandom_range(0, 15));
                default: bus.back_pressure = '0;
            endcase
            @(negedge clk); #1;
            if (done_seen) got = 1;
            @(posedge clk); #1;
        end
        bus.start = 0;
        bus.back_pressure = '0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: got no done expected done (home %0d nr %0d nn %0d)", home, nr, nn);
        end
        off  = done_cyc - t0;
        foff = (first_v < 0) ? -1 : first_v - t0;
    endtask

    task automatic check_lanes(input string tag, input int exp[$]);
        chk(tag, 128'(lane_log.size()), 128'(exp.size()));
        for (int i = 0; i < exp.size() && i < lane_log.size(); i++)
            chk(tag, 128'(lane_log[i]), 128'(exp[i]));
    endtask

    initial begin
        int off, foff, nr, nn;
        bit home;
        int exp_l[$];
        int pr[$];
        int pn[$];

        fill_mem();
        bus.start = 0; bus.home_cell = 0; bus.num_ref = '0; bus.num_nbr = '0;
        bus.back_pressure = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // Pin the model's enumeration
        make_pairs(1, 3, 3, pr, pn);
        chk("model_home_cnt", 128'(pr.size()), 128'(3));
        if (pr.size() == 3) begin
            chk("model_home_p0", 128'({pr[0], pn[0]}), 128'({32'd0, 32'd1}));
            chk("model_home_p1", 128'({pr[1], pn[1]}), 128'({32'd0, 32'd2}));
            chk("model_home_p2", 128'({pr[2], pn[2]}), 128'({32'd1, 32'd2}));
        end
        make_pairs(0, 2, 3, pr, pn);
        chk("model_nh_cnt", 128'(pr.size()), 128'(6));
        if (pr.size() == 6) chk("model_nh_p3", 128'({pr[3], pn[3]}), 128'({32'd1, 32'd0}));

        // Non-home 2x3, free lanes
        do_job(0, 2, 3, 0, off, foff);
        chk("t1_done_off", 128'(off), 128'(9));
        chk("t1_first_valid", 128'(foff), 128'(3));
        chk("t1_count", 128'(v_cnt), 128'(6));
        exp_l = '{0, 1, 2, 3, 0, 1};
        check_lanes("t1_lanes", exp_l);

        // Home cell, 3 particles: three half-shell pairs
        do_job(1, 3, 3, 0, off, foff);
        chk("home_count", 128'(v_cnt), 128'(3));
        chk("home_done_off", 128'(off), 128'(6));
        exp_l = '{2, 3, 0};
        check_lanes("home_lanes", exp_l);

        // Lane 1 held off
        do_job(0, 2, 3, 1, off, foff);
        chk("skip_done_off", 128'(off), 128'(9));
        exp_l = '{2, 3, 0, 2, 3, 0};
        check_lanes("skip_lanes", exp_l);

        // Full stall for 5 cycles mid-job
        do_job(0, 2, 3, 2, off, foff);
        chk("stall_done_off", 128'(off), 128'(14));
        chk("stall_count", 128'(v_cnt), 128'(6));
        exp_l = '{1, 2, 3, 0, 1, 2};
        check_lanes("stall_lanes", exp_l);

        // Empty jobs, with a stray start while busy
        do_job(0, 0, 5, 4, off, foff);
        chk("empty_ref_done_off", 128'(off), 128'(4));
        chk("empty_ref_count", 128'(v_cnt), 128'(0));
        do_job(1, 4, 1, 4, off, foff);
        chk("empty_home_done_off", 128'(off), 128'(4));
        chk("empty_home_count", 128'(v_cnt), 128'(0));

        // Reset during RUN with pairs in flight
        fill_mem();
        bus.home_cell = 0; bus.num_ref = AW'(3); bus.num_nbr = AW'(3);
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        @(negedge clk); #1;
        chk("mid_rst_busy", 128'(bus.busy), 128'(0));
        chk("mid_rst_valid", 128'(bus.input_valid), 128'(0));
        chk("mid_rst_refx", 128'(bus.refx), 128'(0));
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        do_job(0, 2, 2, 0, off, foff);
        chk("post_rst_done_off", 128'(off), 128'(7));
        exp_l = '{0, 1, 2, 3};
        check_lanes("post_rst_lanes", exp_l);

        // Random jobs against the model
        for (int k = 0; k < 30; k++) begin
            fill_mem();
            home = 1'($urandom);
            nr   = $urandom_range(0, 9);
            nn   = $urandom_range(0, 9);
            make_pairs(home, nr, nn, pr, pn);
            do_job(home, nr, nn, 3, off, foff);
            chk("rand_count", 128'(v_cnt), 128'(pr.size()));
        end

        // Maximum counts
        do_job(0, 127, 1, 0, off, foff);
        chk("max_ref_count", 128'(v_cnt), 128'(127));
        do_job(1, 127, 127, 3, off, foff);
        chk("max_home_count", 128'(v_cnt), 128'(8001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/filter_pair_generator.md
Name: filter_pair_generator

Overview:
- Produces particle pairs for the filter bank (the initiator side of its input_valid / back_pressure interface).
- On start, iterates every (reference, neighbor) particle index pair between a reference cell and a neighbor cell, reading coordinates from two position memories.
- Dispatches one pair per cycle, round-robin, to a filter lane whose back pressure is deasserted.
- In a home cell (reference cell = neighbor cell), emits only the half-shell pairs n > r.

Parameters:
- DATA_WIDTH, 32, width of one coordinate (IEEE single).
- NUM_FILTER, 4, number of filter lanes driven.
- PARTICLE_ADDR_WIDTH, 7, width of particle index, memory addresses and counts.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- home_cell  in  1  sampled with start; 1 = same cell, half-shell pairing
- num_ref  in  PARTICLE_ADDR_WIDTH  reference particle count, sampled with start
- num_nbr  in  PARTICLE_ADDR_WIDTH  neighbor particle count, sampled with start
- ref_rd_addr  out  PARTICLE_ADDR_WIDTH  reference memory read address
- ref_rd_data  in  3*DATA_WIDTH  {z,y,x}, valid one cycle after address
- nbr_rd_addr  out  PARTICLE_ADDR_WIDTH  neighbor memory read address
- nbr_rd_data  in  3*DATA_WIDTH  {z,y,x}, valid one cycle after address
- back_pressure  in  NUM_FILTER  per-lane stop request from the filter bank
- input_valid  out  NUM_FILTER  one-hot or zero; lane i receives a pair this cycle
- refx, refy, refz  out  NUM_FILTER*DATA_WIDTH each  per-lane reference coordinates
- neighborx, neighbory, neighborz  out  NUM_FILTER*DATA_WIDTH each  per-lane neighbor coordinates
- busy  out  1  high from the first RUN cycle through the done cycle
- done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0: input_valid, all coordinate buses, both rd_addr, busy, done. Counters, round-robin pointer and pipeline registers cleared. In-flight pairs are dropped.
- Outputs are registered. ref_rd_addr = r counter; nbr_rd_addr = n counter.
- States:
  - IDLE: start latches home_cell/num_ref/num_nbr; r=0; n=home?1:0; ptr unchanged; go RUN.
  - RUN: issue-or-stall each cycle. The cycle of the last issue, or a RUN cycle with nothing to issue (empty job), goes to DRAIN.
  - DRAIN: exactly 2 cycles (pipeline flush), then DONE.
  - DONE: done=1 for 1 cycle; busy=1; go IDLE.
- Empty job: num_ref=0, num_nbr=0, or (home_cell and num_nbr<2). Nothing is issued.
- Lane select in RUN:
  - Scan lanes ptr, ptr+1, … (mod NUM_FILTER) and pick the first with back_pressure=0.
  - If found: issue (r,n) to that lane, then ptr = lane+1 mod NUM_FILTER.
  - If all lanes are pressured: stall. r, n and ptr hold; no issue.
  - back_pressure is sampled in the issue cycle only. A pair already issued completes even if its lane raises back pressure afterwards; the filter buffer slack covers this.
- Index advance on issue:
  - If n+1 < num_nbr: n++.
  - Else: r++ and n = home ? r_new+1 : 0. The job is finished if r_new == num_ref, or if home and n_new >= num_nbr.
  - No bubble cycles between reference particles.
- Home cell uses num_nbr as the bound for both r and n.
- Pipeline: issue in cycle k → rd_data valid in k+1 → input_valid[lane] and the lane's six coordinate slices loaded, visible in k+2. Latency from issue to valid is 2 cycles.
- Non-selected lanes hold their previous coordinate values; their input_valid is 0.
- Coordinate slice for lane i is [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH], matching the filter bank packing. x = bits [DATA_WIDTH-1:0] of rd_data, y the next DATA_WIDTH bits, z the top.
- start while not IDLE is ignored.
- Counts are unsigned. The r/n comparisons use PARTICLE_ADDR_WIDTH+1 bits so that r+1 does not wrap at the maximum count.

Test Plan:
- Non-home run: num_ref=2, num_nbr=3, no back pressure, start at T → pairs (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) on lanes 0,1,2,3,0,1. input_valid at T+3..T+8; done at T+9; busy T+1..T+9. Coordinates match memory contents at those addresses.
- Home cell: home_cell=1, num_ref=num_nbr=3 → exactly 3 pairs (0,1),(0,2),(1,2); no r==n and no duplicate pairs.
- Lane skipping: back_pressure=4'b0010 held, 6 pairs → lanes 0,2,3,0,2,3; lane 1 never valid.
- Full stall and resume: back_pressure=4'b1111 for 5 cycles mid-job → no new issues during the stall. Pairs already issued still appear. Sequence resumes at the next (r,n) in order with no loss or duplicate; done is delayed by 5 cycles.
- Empty jobs: num_ref=0; and home_cell=1 with num_nbr=1; start at T → no input_valid, done at T+4. A start pulse during busy is ignored.
- Reset mid-run: rst low for 1 cycle during RUN → all outputs 0 immediately and state IDLE. A subsequent start runs a full, correct job from pair (0,0).
